// File: rtl/present_ecb_ctrl.sv
// present_ecb_ctrl
// ----------------
// Sequencing controller for an iterative PRESENT-80 encryption core operating
// in ECB mode, one block at a time. A plaintext/key pair is registered, the
// core is loaded for one cycle, then runs ROUNDS round cycles. The core's
// combinational output (state XOR current round key) is captured as the
// ciphertext, which is held until the downstream side accepts it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE.
// Neither ready depends combinationally on the opposite valid. Once out_valid
// rises, out_data is held stable until the transfer completes.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   plaintext/key pair offered
//   in_ready   pair accepted this cycle (state IDLE)
//   in_data    64-bit plaintext
//   in_key     80-bit cipher key
//   out_valid  ciphertext available (state DONE)
//   out_ready  downstream accepts the ciphertext
//   out_data   registered 64-bit ciphertext
//   core_load  one-cycle load strobe to the core (state LOAD)
//   core_idat  plaintext to the core, from the plaintext register
//   core_key   key to the core, from the key register
//   core_odat  combinational round output from the core
//   busy       high in every state except IDLE
//   done_cnt   count of completed output handshakes, wraps at 16 bits
module present_ecb_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        core_load,
  output logic [63:0] core_idat,
  output logic [79:0] core_key,
  input  logic [63:0] core_odat,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  // Counter value on the final RUN cycle.
  localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [63:0] pt_q;
  logic [79:0] key_q;
  logic [15:0] done_cnt_q;
  logic        in_fire;
  logic        out_fire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_load = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        core_load = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Round counter: 1 on the first RUN cycle, ROUNDS on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        LOAD:    cnt <= 5'd1;
        RUN:     cnt <= cnt + 5'd1;
        default: cnt <= 5'd0;
      endcase
    end
  end

  // Plaintext and key registers only change on an input handshake, so the
  // core sees a stable pair even if in_data moves while the block runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_q  <= 64'd0;
      key_q <= 80'd0;
    end else if (in_fire) begin
      pt_q  <= in_data;
      key_q <= in_key;
    end
  end

  // During CAPT the core presents final state XOR K32, i.e. the ciphertext.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= 64'd0;
    end else if (state == CAPT) begin
      out_data <= core_odat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= 16'd0;
    end else if (out_fire) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign core_idat = pt_q;
  assign core_key  = key_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_present_ecb_ctrl.sv
// Bench for present_ecb_ctrl: attaches a behavioural PRESENT-80 core, drives
// directed and random traffic, and checks every output on each falling edge
// against a timeline model of the block.
module tb_present_ecb_ctrl;

  localparam int ROUNDS = 31;

  // Clock / reset / DUT signals
  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data   = '0;
  logic [79:0] in_key    = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        core_load;
  logic [63:0] core_idat;
  logic [79:0] core_key;
  logic [63:0] core_odat;
  logic        busy;
  logic [15:0] done_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  present_ecb_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .core_load (core_load),
    .core_idat (core_idat),
    .core_key  (core_key),
    .core_odat (core_odat),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  // PRESENT-80 primitives
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      idx = (i * 16) % 63;
      r[idx] = s[i];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox4(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  function automatic logic [63:0] present_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int i = 1; i <= 31; i++) begin
      s = p_layer(s_layer(s ^ k[79:16]));
      k = key_update(k, 5'(i));
    end
    return s ^ k[79:16];
  endfunction

  // Attached iterative core: load on core_load, otherwise one round per edge.
  logic [63:0] c_state = '0;
  logic [79:0] c_key   = '0;
  logic [4:0]  c_rnd   = '0;

  always @(posedge clk) begin
    if (core_load) begin
      c_state <= core_idat;
      c_key   <= core_key;
      c_rnd   <= 5'd1;
    end else begin
      c_state <= p_layer(s_layer(c_state ^ c_key[79:16]));
      c_key   <= key_update(c_key, c_rnd);
      c_rnd   <= c_rnd + 5'd1;
    end
  end

  assign core_odat = c_state ^ c_key[79:16];

  // Timeline model: m_age counts edges since the accepting edge (1 = LOAD
  // cycle, ciphertext visible from ROUNDS+3 on).
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  logic [63:0] m_pt   = '0;
  logic [79:0] m_key  = '0;
  logic [63:0] m_exp  = '0;
  logic [63:0] m_out  = '0;
  logic [15:0] m_done = '0;
  logic [15:0] m_off  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_pt   <= '0;
      m_key  <= '0;
      m_out  <= '0;
      m_done <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 1;
        m_pt   <= in_data;
        m_key  <= in_key;
        m_exp  <= present_encrypt(in_data, in_key);
      end
    end else if (m_age >= ROUNDS + 3) begin
      if (out_ready) begin
        m_busy <= 1'b0;
        m_done <= m_done + 16'd1;
      end
    end else begin
      if (m_age == ROUNDS + 2) m_out <= m_exp;
      m_age <= m_age + 1;
    end
  end

  // Scoreboard helpers
  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    check("in_ready",  80'(in_ready),  80'(!m_busy));
    check("busy",      80'(busy),      80'(m_busy));
    check("core_load", 80'(core_load), 80'(m_busy && m_age == 1));
    check("out_valid", 80'(out_valid), 80'(m_busy && m_age >= ROUNDS + 3));
    check("out_data",  80'(out_data),  80'(m_out));
    check("done_cnt",  80'(done_cnt),  80'(16'(m_done + m_off)));
    check("core_idat", 80'(core_idat), 80'(m_pt));
    check("core_key",  80'(core_key),  m_key);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
  endtask

  // Driver: offer one pair once idle, return ciphertext and cycles to out_valid.
  task automatic run_block(input logic [63:0] pt, input logic [79:0] key,
                           output logic [63:0] ct, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    check("idle_before_send", 80'(in_ready), 80'(1));
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("out_valid_seen", 80'(out_valid), 80'(1));
    ct = out_data;
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v_pt [4];
    logic [79:0] v_key[4];
    logic [63:0] v_ct [4];
    logic [63:0] ct, d, pt;
    logic [79:0] key;
    logic [15:0] dc;
    int          lat, g;

    v_pt[0] = 64'h0;                 v_key[0] = 80'h0;
    v_pt[1] = 64'hFFFFFFFFFFFFFFFF;  v_key[1] = {80{1'b1}};
    v_pt[2] = 64'h0;                 v_key[2] = {80{1'b1}};
    v_pt[3] = 64'hFFFFFFFFFFFFFFFF;  v_key[3] = 80'h0;
    v_ct[0] = 64'h5579C1387B228445;
    v_ct[1] = 64'h3333DCD3213210D2;
    v_ct[2] = 64'hE72C46C0F5945049;
    v_ct[3] = 64'hA112FFC72F68417B;

    // Pin the reference cipher to the published vectors.
    for (int i = 0; i < 4; i++) begin
      check("ref_cipher", 80'(present_encrypt(v_pt[i], v_key[i])), 80'(v_ct[i]));
    end

    // Reset
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  80'(in_ready),  80'(1));
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_out_data",  80'(out_data),  80'(0));
    check("rst_done_cnt",  80'(done_cnt),  80'(0));
    check("rst_core_key",  core_key,       80'(0));
    rst = 1'b0;

    // Known-answer blocks, out_ready held high the whole time.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_block(v_pt[i], v_key[i], ct, lat);
      check("kat_ct", 80'(ct), 80'(v_ct[i]));
      check("kat_latency", 80'(lat), 80'(34));
    end
    tick();
    check("kat_done_cnt", 80'(done_cnt), 80'(4));

    // Back-pressure in DONE for 10 cycles.
    out_ready = 1'b0;
    pt  = {$urandom, $urandom};
    key = rand_key();
    run_block(pt, key, ct, lat);
    check("bp_ct", 80'(ct), 80'(present_encrypt(pt, key)));
    d  = out_data;
    dc = done_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", 80'(out_valid), 80'(1));
      check("bp_out_data",  80'(out_data),  80'(d));
      check("bp_in_ready",  80'(in_ready),  80'(0));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", 80'(in_ready),  80'(1));
    check("bp_release_ov",   80'(out_valid), 80'(0));
    check("bp_release_cnt",  80'(done_cnt),  80'(16'(dc + 16'd1)));

    // Reset in the middle of RUN (cnt = 15), then accept on the first edge.
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    in_key   = rand_key();
    tick();
    in_valid = 1'b0;
    g = 0;
    while (m_age != 16 && g < 100) begin
      tick();
      g++;
    end
    check("mid_rst_reached", 80'(busy), 80'(1));
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_in_ready",  80'(in_ready),  80'(1));
    check("mid_rst_out_valid", 80'(out_valid), 80'(0));
    check("mid_rst_done_cnt",  80'(done_cnt),  80'(0));
    rst = 1'b0;
    run_block(v_pt[0], v_key[0], ct, lat);
    check("post_rst_ct",  80'(ct),  80'(v_ct[0]));
    check("post_rst_lat", 80'(lat), 80'(34));

    // in_valid toggling with changing data while the block runs.
    tick();
    pt  = 64'h0123456789ABCDEF;
    key = rand_key();
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    tick();
    for (int i = 0; i < 25; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      in_key   = rand_key();
      tick();
      check("hold_core_idat", 80'(core_idat), 80'(pt));
      check("hold_core_key",  core_key,       key);
    end
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 100) begin
      tick();
      g++;
    end
    check("hold_ct", 80'(out_data), 80'(present_encrypt(pt, key)));

    // Random traffic with random back-pressure and rare resets.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = {$urandom, $urandom};
      in_key    = rand_key();
      out_ready = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    // Counter wrap via backdoor preload.
    g = 0;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    force dut.done_cnt_q = 16'hFFFF;
    m_off = 16'hFFFF - m_done;
    #1;
    release dut.done_cnt_q;
    #1;
    check("wrap_preload", 80'(done_cnt), 80'(16'hFFFF));
    run_block(v_pt[1], v_key[1], ct, lat);
    check("wrap_ct", 80'(ct), 80'(v_ct[1]));
    tick();
    check("wrap_done_cnt", 80'(done_cnt), 80'(0));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
